// File: rtl/adc_spi3w_bridge.sv
// rtl/adc_spi3w_bridge.sv - host 4-wire SPI to ADC 3-wire SPI (shared SDIO) bridge
//
// Ports:
//   clk, reset            system clock, asynchronous active-low reset
//   spi_en                bridge enable, 0 parks every ADC line idle
//   ch_sel[CHW-1:0]       target channel, latched while idle
//   sck, csn, mosi, miso  host SPI, mode 0, MSB first
//   adc_sck, adc_csn[NCH-1:0]            ADC clock and per-channel chip selects
//   adc_sdio_o, adc_sdio_t, adc_sdio_i   SDIO pad drive, tristate (1 = high-Z), sample
//   rd_active             high while the read data phase is running
//   frame_err             one-clk pulse when a malformed frame ends
//   xfer_cnt[15:0]        completed-frame counter, wraps
//
// Build option: define ADC_SPI_STREAM_EN to let the data phase run for any
// number of words until csn rises; otherwise a frame carries exactly one word.
`timescale 1ns/1ps
module adc_spi3w_bridge #(
    parameter int NCH         = 2,
    parameter int INSTR_BITS  = 16,
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2,
    localparam int CHW        = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           spi_en,
    input  logic [CHW-1:0] ch_sel,
    input  logic           sck,
    input  logic           csn,
    input  logic           mosi,
    output logic           miso,
    output logic           adc_sck,
    output logic [NCH-1:0] adc_csn,
    output logic           adc_sdio_o,
    output logic           adc_sdio_t,
    input  logic           adc_sdio_i,
    output logic           rd_active,
    output logic           frame_err,
    output logic [15:0]    xfer_cnt
);
    typedef enum logic [2:0] {IDLE, INSTR, WR_DATA, RD_DATA, DONE} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sck_sr, csn_sr, mosi_sr;
    logic                   sck_prev;
    logic                   sck_s, csn_s, mosi_s, rx_edge;
    logic [5:0]             bit_cnt;
    logic                   rw_r;
    logic [CHW-1:0]         ch_r;
    logic                   ch_ok;
    logic                   word_done;  // at least one data word finished
    logic                   extra_r;    // sck edge seen after the single word
    logic                   leave;
    logic                   err_now;

    assign sck_s   = sck_sr[SYNC_STAGES-1];
    assign csn_s   = csn_sr[SYNC_STAGES-1];
    assign mosi_s  = mosi_sr[SYNC_STAGES-1];
    assign rx_edge = sck_s & ~sck_prev;
    assign ch_ok   = (32'(ch_r) < NCH);

    // Idle levels: sck and csn high, mosi low, so reset never fakes an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sck_sr   <= '1;
            csn_sr   <= '1;
            mosi_sr  <= '0;
            sck_prev <= 1'b1;
        end else begin
            sck_sr   <= {sck_sr[SYNC_STAGES-2:0], sck};
            csn_sr   <= {csn_sr[SYNC_STAGES-2:0], csn};
            mosi_sr  <= {mosi_sr[SYNC_STAGES-2:0], mosi};
            sck_prev <= sck_s;
        end
    end

    // The ADC sees the raw host lines; only the turnaround is clk-timed.
    assign adc_sck    = spi_en ? sck : 1'b1;
    assign adc_sdio_o = spi_en ? mosi : 1'b0;
    assign miso       = (state == RD_DATA) ? adc_sdio_i : 1'b0;

    always_comb begin
        adc_csn = '1;
        for (int i = 0; i < NCH; i++) begin
            if (spi_en && ch_ok && (32'(ch_r) == i))
                adc_csn[i] = csn;
        end
    end

    assign leave   = (state != IDLE) && (csn_s || !spi_en);
    assign err_now = (state == INSTR)
                  || (((state == WR_DATA) || (state == RD_DATA)) && (bit_cnt != 6'd0))
                  || !ch_ok || extra_r;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            rw_r       <= 1'b0;
            ch_r       <= '0;
            adc_sdio_t <= 1'b1;
            frame_err  <= 1'b0;
            xfer_cnt   <= '0;
            rd_active  <= 1'b0;
            word_done  <= 1'b0;
            extra_r    <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            rd_active <= (state == RD_DATA);
            if (leave) begin
                state      <= IDLE;
                bit_cnt    <= '0;
                adc_sdio_t <= 1'b1;
                frame_err  <= err_now;
                if (!err_now && word_done)
                    xfer_cnt <= xfer_cnt + 16'd1;
            end else begin
                case (state)
                    IDLE: begin
                        ch_r       <= ch_sel;
                        bit_cnt    <= '0;
                        word_done  <= 1'b0;
                        extra_r    <= 1'b0;
                        adc_sdio_t <= 1'b1;
                        if (!csn_s && spi_en) begin
                            state      <= INSTR;
                            adc_sdio_t <= 1'b0;
                        end
                    end
                    INSTR: begin
                        if (rx_edge) begin
                            if (bit_cnt == 6'd0)
                                rw_r <= mosi_s;
                            if (bit_cnt == 6'(INSTR_BITS - 1)) begin
                                bit_cnt    <= '0;
                                state      <= rw_r ? RD_DATA : WR_DATA;
                                adc_sdio_t <= rw_r;  // release SDIO for the ADC on reads
                            end else begin
                                bit_cnt <= bit_cnt + 6'd1;
                            end
                        end
                    end
                    WR_DATA, RD_DATA: begin
                        if (rx_edge) begin
                            if (bit_cnt == 6'(DATA_BITS - 1)) begin
                                bit_cnt   <= '0;
                                word_done <= 1'b1;
`ifdef ADC_SPI_STREAM_EN
`else
                                state      <= DONE;
                                adc_sdio_t <= 1'b1;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 6'd1;
                            end
                        end
                    end
                    DONE: begin
                        if (rx_edge)
                            extra_r <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_adc_spi3w_bridge.sv
// tb/tb_adc_spi3w_bridge.sv - directed self-checking bench for adc_spi3w_bridge
`timescale 1ns/1ps
module tb_adc_spi3w_bridge;
    localparam int HALF = 40;

    logic        clk = 1'b0;
    logic        reset, spi_en, sck, csn, mosi, adc_sdio_i;
    logic [0:0]  ch_sel;
    logic        miso, adc_sck, adc_sdio_o, adc_sdio_t, rd_active, frame_err;
    logic [1:0]  adc_csn;
    logic [15:0] xfer_cnt;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          err_seen = 0;
    int          exp_err  = 0;
    logic [15:0] exp_cnt  = 16'd0;
    logic        exp_q[$];
    logic        last_t, last_miso, last_o;
    logic        t_hi_seen, o_bad_seen;
    logic        exp_bit;

    adc_spi3w_bridge dut (
        .clk(clk), .reset(reset), .spi_en(spi_en), .ch_sel(ch_sel),
        .sck(sck), .csn(csn), .mosi(mosi), .miso(miso),
        .adc_sck(adc_sck), .adc_csn(adc_csn),
        .adc_sdio_o(adc_sdio_o), .adc_sdio_t(adc_sdio_t), .adc_sdio_i(adc_sdio_i),
        .rd_active(rd_active), .frame_err(frame_err), .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_err === 1'b1) err_seen++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, input logic sdio);
        mosi       = b;
        adc_sdio_i = sdio;
        #HALF;
        last_miso  = miso;
        last_t     = adc_sdio_t;
        last_o     = adc_sdio_o;
        if (last_t !== 1'b0) t_hi_seen = 1'b1;
        if (last_o !== b) o_bad_seen = 1'b1;
        sck = 1'b1;
        #HALF;
        sck = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(w[i], 1'b0);
    endtask

    task automatic frame_start();
        csn = 1'b0;
        t_hi_seen = 1'b0;
        o_bad_seen = 1'b0;
        #HALF;
    endtask

    task automatic frame_end();
        #HALF;
        csn = 1'b1;
        #(HALF * 3);
    endtask

    initial begin
        logic [7:0] rd_word;
        reset = 1'b0; spi_en = 1'b1; sck = 1'b0; csn = 1'b1; mosi = 1'b0;
        adc_sdio_i = 1'b0; ch_sel = 1'b0;
        #40;
        chk("rst_sdio_t", adc_sdio_t, 1);
        chk("rst_xfer", xfer_cnt, 0);
        chk("rst_rd_active", rd_active, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_miso", miso, 0);
        chk("rst_csn", adc_csn, 2'b11);
        reset = 1'b1;
        #(HALF * 2);

        // Write frame on channel 1
        ch_sel = 1'b1;
        frame_start();
        chk("wr_csn", adc_csn, 2'b01);
        chk("wr_t_start", adc_sdio_t, 0);
        send_word(32'h0014, 16);
        send_word(32'hA5, 8);
        chk("wr_t_low", t_hi_seen, 0);
        chk("wr_sdio_o", o_bad_seen, 0);
        frame_end();
        exp_cnt = exp_cnt + 16'd1;
        chk("wr_xfer", xfer_cnt, exp_cnt);
        chk("wr_err", err_seen, exp_err);

        // Read frame on channel 0, ADC returns 0x3C
        ch_sel = 1'b0;
        rd_word = 8'h3C;
        for (int i = 7; i >= 0; i--) exp_q.push_back(rd_word[i]);
        frame_start();
        chk("rd_csn", adc_csn, 2'b10);
        send_word(32'h4000, 15);   // top 15 bits of 0x8001
        mosi = 1'b1;
        #HALF;
        sck = 1'b1;
        #1;
        chk("rd_t_before_turn", adc_sdio_t, 0);
        #(HALF - 1);
        sck = 1'b0;
        chk("rd_t_after_turn", adc_sdio_t, 1);
        for (int i = 7; i >= 0; i--) begin
            send_bit(1'b0, rd_word[i]);
            exp_bit = exp_q.pop_front();
            chk($sformatf("rd_miso_bit%0d", i), last_miso, exp_bit);
            if (i == 4) chk("rd_active_hi", rd_active, 1);
        end
        frame_end();
        exp_cnt = exp_cnt + 16'd1;
        chk("rd_active_lo", rd_active, 0);
        chk("rd_miso_idle", miso, 0);
        chk("rd_xfer", xfer_cnt, exp_cnt);
        chk("rd_err", err_seen, exp_err);

        // Truncated instruction
        frame_start();
        send_word(32'h0014 >> 6, 10);
        frame_end();
        exp_err++;
        chk("trunc_err", err_seen, exp_err);
        chk("trunc_xfer", xfer_cnt, exp_cnt);
        chk("trunc_idle_t", adc_sdio_t, 1);

        // Write instruction followed by three bytes
        frame_start();
        send_word(32'h0014, 16);
        send_word(32'h11, 8);
        send_bit(1'b0, 1'b0);
`ifdef ADC_SPI_STREAM_EN
        chk("multi_t_byte2", last_t, 0);
`else
        chk("multi_t_byte2", last_t, 1);
`endif
        send_word(32'h22, 7);
        send_word(32'h33, 8);
        frame_end();
`ifdef ADC_SPI_STREAM_EN
        exp_cnt = exp_cnt + 16'd1;
`else
        exp_err++;
`endif
        chk("multi_err", err_seen, exp_err);
        chk("multi_xfer", xfer_cnt, exp_cnt);

        // Reset mid read at data bit 4
        frame_start();
        send_word(32'h8001, 16);
        send_word(32'h0, 4);
        #(HALF / 2);
        reset = 1'b0;
        #1;
        exp_cnt = 16'd0;
        chk("midrst_t", adc_sdio_t, 1);
        chk("midrst_xfer", xfer_cnt, exp_cnt);
        csn = 1'b1;
        #HALF;
        reset = 1'b1;
        #(HALF * 2);
        chk("midrst_err", err_seen, exp_err);
        frame_start();
        send_word(32'h0014, 16);
        send_word(32'h5A, 8);
        frame_end();
        exp_cnt = exp_cnt + 16'd1;
        chk("postrst_xfer", xfer_cnt, exp_cnt);
        chk("postrst_err", err_seen, exp_err);

        // Disable in the middle of an instruction
        frame_start();
        send_word(32'h0014 >> 11, 5);
        spi_en = 1'b0;
        #1;
        chk("dis_sck", adc_sck, 1);
        chk("dis_csn", adc_csn, 2'b11);
        #19;
        chk("dis_t", adc_sdio_t, 1);
        csn = 1'b1;
        #HALF;
        spi_en = 1'b1;
        #(HALF * 2);
        exp_err++;
        chk("dis_err", err_seen, exp_err);
        chk("dis_xfer", xfer_cnt, exp_cnt);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
